// File: rtl/crc_pkg.sv
// Shared types, constants and CRC-16/CCITT-FALSE byte step for the CRC memory path.
package crc_pkg;

  localparam int unsigned MEM_DEPTH  = 1024;
  localparam int unsigned MEM_ADDR_W = $clog2(MEM_DEPTH);
  localparam logic [15:0] CRC16_POLY = 16'h1021;
  localparam logic [15:0] CRC16_INIT = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE,
    ACCEPT,
    WRITE,
    DONE
  } loader_state_t;

  // MSB-first byte update: eight shift/XOR steps, no reflection, no final XOR.
  function automatic logic [15:0] crc16_byte(input logic [15:0] crc,
                                             input logic [7:0]  data,
                                             input logic [15:0] poly = CRC16_POLY);
    logic [15:0] c;
    c = crc ^ {data, 8'h00};
    for (int unsigned i = 0; i < 8; i++) begin
      c = c[15] ? ((c << 1) ^ poly) : (c << 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/crc_mem_loader_if.sv
// Byte-stream handshake and memory write bus of the CRC memory loader.
interface crc_mem_loader_if
  import crc_pkg::*;
#(
  parameter int unsigned ADDR_W = MEM_ADDR_W
);
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;

  // Environment side: byte source and memory sink.
  modport master (
    output in_valid, in_data,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  // Loader side.
  modport slave (
    input  in_valid, in_data,
    output in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/crc_mem_loader_crc16.sv
// Combinational byte-wise CRC-16 step; reusable by the downstream checker.
module crc16_byte_update
  import crc_pkg::*;
#(
  parameter logic [15:0] POLY = CRC16_POLY
) (
  input  logic [15:0] crc_i,
  input  logic [7:0]  data_i,
  output logic [15:0] crc_o
);

  // Unrolled eight-step update of the current CRC with one byte.
  always_comb begin
    crc_o = crc16_byte(crc_i, data_i, POLY);
  end

endmodule

// File: rtl/crc_mem_loader.sv
// Write side of the CRC memory path: stream bytes into memory from address 0
// while accumulating CRC-16/CCITT-FALSE over exactly the bytes written.
module crc_mem_loader
  import crc_pkg::*;
#(
  parameter int unsigned DEPTH    = MEM_DEPTH,
  parameter int unsigned ADDR_W   = MEM_ADDR_W,
  parameter logic [15:0] CRC_POLY = CRC16_POLY,
  parameter logic [15:0] CRC_INIT = CRC16_INIT
) (
  input  logic              clk50m,
  input  logic              rst_n,
  input  logic              load_start,
  input  logic [ADDR_W:0]   load_len,
  crc_mem_loader_if.slave   bus,
  output logic [15:0]       crc_out,
  output logic              load_done,
  output logic              busy
);

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  loader_state_t     state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [15:0]       crc_q, crc_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;
  logic [ADDR_W:0]   len_sat;
  logic [ADDR_W:0]   cnt_inc;
  logic [15:0]       crc_upd;

  crc16_byte_update #(
    .POLY(CRC_POLY)
  ) u_crc (
    .crc_i (crc_q),
    .data_i(wdata_q),
    .crc_o (crc_upd)
  );

  // Length saturation and count increment used by the FSM.
  always_comb begin
    len_sat = (load_len > DEPTH_L) ? DEPTH_L : load_len;
    cnt_inc = cnt_q + 1'b1;
  end

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    crc_d   = crc_q;
    case (state_q)
      IDLE, DONE: begin
        if (load_start) begin
          addr_d  = '0;
          cnt_d   = '0;
          crc_d   = CRC_INIT;
          len_d   = len_sat;
          state_d = (len_sat == '0) ? DONE : ACCEPT;
        end
      end
      ACCEPT: begin
        if (bus.in_valid) begin
          wdata_d = bus.in_data;
          state_d = WRITE;
        end
      end
      WRITE: begin
        crc_d = crc_upd;
        cnt_d = cnt_inc;
        // Address only advances when another byte follows, so it stops at DEPTH-1.
        if (cnt_inc == len_q) begin
          state_d = DONE;
        end else begin
          addr_d  = addr_q + 1'b1;
          state_d = ACCEPT;
        end
      end
      default: state_d = IDLE;
    endcase
    done_d = (state_d == DONE);
    busy_d = (state_d == ACCEPT) || (state_d == WRITE);
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk50m or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      crc_q   <= CRC_INIT;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      crc_q   <= crc_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.in_ready  = (state_q == ACCEPT);
  assign bus.mem_we    = (state_q == WRITE);
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign crc_out       = crc_q;
  assign load_done     = done_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_crc_mem_loader.sv
// Self-checking bench for crc_mem_loader: transaction-level model plus directed vectors.
module tb_crc_mem_loader;

  localparam int unsigned AW  = 10;
  localparam int unsigned DEP = 1024;

  logic          clk50m = 1'b0;
  logic          rst_n = 1'b0;
  logic          load_start = 1'b0;
  logic [AW:0]   load_len = '0;
  logic [15:0]   crc_out;
  logic          load_done;
  logic          busy;

  crc_mem_loader_if #(.ADDR_W(AW)) bus ();

  crc_mem_loader #(
    .DEPTH   (DEP),
    .ADDR_W  (AW),
    .CRC_POLY(16'h1021),
    .CRC_INIT(16'hFFFF)
  ) dut (
    .clk50m    (clk50m),
    .rst_n     (rst_n),
    .load_start(load_start),
    .load_len  (load_len),
    .bus       (bus),
    .crc_out   (crc_out),
    .load_done (load_done),
    .busy      (busy)
  );

  always #10 clk50m = ~clk50m;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference CRC over a whole message, bit-serial feedback form.
  function automatic logic [15:0] ref_crc(input byte unsigned msg[$]);
    logic [15:0]  c;
    logic         fb;
    byte unsigned cur;
    c = 16'hFFFF;
    foreach (msg[k]) begin
      cur = msg[k];
      for (int b = 7; b >= 0; b--) begin
        fb = c[15] ^ cur[b];
        c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
      end
    end
    return c;
  endfunction

  // Model state: what the current load has accepted and written.
  bit            active = 1'b0;
  int unsigned   exp_len = 0;
  bit            hs_prev = 1'b0;
  byte unsigned  wr_bytes[$];
  byte unsigned  acc[$];
  logic [15:0]   exp_crc = 16'hFFFF;
  int            last_addr = -1;
  logic [7:0]    tb_mem [DEP];

  // Compare process: every cycle, DUT outputs against the transaction model.
  always @(negedge clk50m) begin
    bit exp_busy;
    if (!rst_n) begin
      chk("rst_busy", busy, 0);
      chk("rst_done", load_done, 0);
      chk("rst_in_ready", bus.in_ready, 0);
      chk("rst_mem_we", bus.mem_we, 0);
      chk("rst_mem_addr", bus.mem_addr, 0);
      chk("rst_mem_wdata", bus.mem_wdata, 0);
      chk("rst_crc", crc_out, 16'hFFFF);
      active  = 1'b0;
      exp_len = 0;
      hs_prev = 1'b0;
      wr_bytes.delete();
      acc.delete();
      exp_crc = 16'hFFFF;
    end else begin
      exp_busy = active && (wr_bytes.size() < exp_len);
      chk("busy", busy, exp_busy);
      chk("load_done", load_done, active && (wr_bytes.size() == exp_len));
      chk("crc_out", crc_out, exp_crc);
      chk("mem_we_latency", bus.mem_we, hs_prev);
      chk("in_ready", bus.in_ready, exp_busy && !hs_prev);
      if (bus.mem_we) begin
        chk("mem_addr", bus.mem_addr, wr_bytes.size());
        if (acc.size() == 0) begin
          chk("write_without_byte", 1, 0);
        end else begin
          chk("mem_wdata", bus.mem_wdata, acc.pop_front());
        end
        tb_mem[bus.mem_addr] = bus.mem_wdata;
        last_addr = int'(bus.mem_addr);
        wr_bytes.push_back(bus.mem_wdata);
        exp_crc = ref_crc(wr_bytes);
      end
      hs_prev = bus.in_valid && bus.in_ready;
      if (hs_prev) acc.push_back(bus.in_data);
      if (load_start && !exp_busy) begin
        active  = 1'b1;
        exp_len = (load_len > DEP) ? DEP : int'(load_len);
        wr_bytes.delete();
        acc.delete();
        exp_crc = 16'hFFFF;
      end
    end
  end

  // Stimulus helpers: all driving happens 1 ns after the rising edge.
  task automatic start_load(input logic [AW:0] len);
    load_start = 1'b1;
    load_len   = len;
    @(posedge clk50m); #1;
    load_start = 1'b0;
  endtask

  task automatic send(input byte unsigned d[$], input bit gaps);
    foreach (d[i]) begin
      bit took;
      int budget;
      took   = 1'b0;
      budget = 0;
      if (gaps) begin
        repeat ($urandom_range(0, 3)) begin
          bus.in_valid = 1'b0;
          @(posedge clk50m); #1;
        end
      end
      bus.in_valid = 1'b1;
      bus.in_data  = d[i];
      while (!took && budget < 50) begin
        @(negedge clk50m);
        took = bus.in_ready;
        @(posedge clk50m); #1;
        budget++;
      end
      if (!took) begin
        chk("send_timeout", took, 1);
        break;
      end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (n < budget) begin
      @(negedge clk50m);
      if (load_done) break;
      n++;
    end
    chk("done_timeout", load_done, 1);
    @(posedge clk50m); #1;
  endtask

  byte unsigned msg9[$] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
  byte unsigned msg5[$] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35};
  byte unsigned zero1[$] = '{8'h00};
  byte unsigned empty[$];
  byte unsigned full[$];

  task automatic check_msg9(input string tag);
    chk({tag, "_crc"}, crc_out, 16'h29B1);
    chk({tag, "_writes"}, wr_bytes.size(), 9);
    chk({tag, "_last_addr"}, last_addr, 8);
    for (int i = 0; i < 9; i++) chk({tag, "_mem"}, tb_mem[i], msg9[i]);
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    for (int i = 0; i < DEP; i++) full.push_back(byte'(i));

    // Pin the reference model itself.
    chk("ref_123456789", ref_crc(msg9), 16'h29B1);
    chk("ref_zero_byte", ref_crc(zero1), 16'hE1F0);
    chk("ref_empty", ref_crc(empty), 16'hFFFF);

    repeat (3) @(posedge clk50m);
    #1;
    chk("reset_crc", crc_out, 16'hFFFF);
    chk("reset_done", load_done, 0);
    rst_n = 1'b1;
    @(posedge clk50m); #1;

    // Check vector with continuous valid.
    start_load(11'd9);
    chk("start_in_ready", bus.in_ready, 1);
    send(msg9, 1'b0);
    wait_done(100);
    check_msg9("cont");

    // Same bytes with random gaps, restarting from DONE.
    for (int i = 0; i < 9; i++) tb_mem[i] = 8'h00;
    start_load(11'd9);
    send(msg9, 1'b1);
    wait_done(100);
    check_msg9("gaps");

    // Zero-length load.
    start_load(11'd0);
    chk("len0_done", load_done, 1);
    chk("len0_crc", crc_out, 16'hFFFF);
    repeat (3) @(posedge clk50m);
    #1;
    chk("len0_writes", wr_bytes.size(), 0);

    // Single zero byte.
    start_load(11'd1);
    send(zero1, 1'b0);
    wait_done(20);
    chk("len1_crc", crc_out, 16'hE1F0);
    chk("len1_writes", wr_bytes.size(), 1);

    // Full depth.
    start_load(11'd1024);
    send(full, 1'b0);
    wait_done(3000);
    chk("full_writes", wr_bytes.size(), 1024);
    chk("full_last_addr", last_addr, 1023);
    chk("full_crc", crc_out, ref_crc(full));
    chk("full_mem_top", tb_mem[1023], 8'hFF);

    // Oversized length saturates at DEPTH; extra valid is not consumed.
    start_load(11'd1100);
    send(full, 1'b0);
    wait_done(3000);
    bus.in_valid = 1'b1;
    repeat (5) @(posedge clk50m);
    #1;
    bus.in_valid = 1'b0;
    chk("sat_writes", wr_bytes.size(), 1024);
    chk("sat_last_addr", last_addr, 1023);
    chk("sat_crc", crc_out, ref_crc(full));

    // load_start during a load is ignored.
    start_load(11'd9);
    fork
      send(msg9, 1'b0);
      begin
        repeat (6) @(posedge clk50m);
        #1;
        load_start = 1'b1;
        load_len   = 11'd3;
        @(posedge clk50m); #1;
        load_start = 1'b0;
      end
    join
    wait_done(100);
    check_msg9("midstart");

    // Reset after five bytes, then a clean reload.
    start_load(11'd9);
    send(msg5, 1'b0);
    @(posedge clk50m); #1;
    chk("pre_rst_writes", wr_bytes.size(), 5);
    #4;
    rst_n = 1'b0;
    #1;
    chk("async_rst_busy", busy, 0);
    chk("async_rst_in_ready", bus.in_ready, 0);
    chk("async_rst_crc", crc_out, 16'hFFFF);
    chk("async_rst_done", load_done, 0);
    @(posedge clk50m); #1;
    rst_n = 1'b1;
    @(posedge clk50m); #1;
    chk("after_rst_done", load_done, 0);
    start_load(11'd9);
    send(msg9, 1'b0);
    wait_done(100);
    check_msg9("reload");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/crc_mem_loader.md
# crc_mem_loader

- Write side of the CRC memory path.
- Accepts a byte stream over a valid/ready handshake and writes consecutive bytes into the 1024×8 data memory from address 0.
- Computes CRC-16/CCITT-FALSE over exactly the bytes written.
- Raises `load_done` with the final CRC when finished, so the memory is ready for the downstream CRC read/check FSM.

## Interface
Parameters:
- `DEPTH`, 1024, memory depth in bytes.
- `ADDR_W`, 10, memory address width (`clog2(DEPTH)`).
- `CRC_POLY`, 16'h1021, CRC generator polynomial.
- `CRC_INIT`, 16'hFFFF, CRC preset value.

Ports:
- `clk50m`  in  1  system clock, 50 MHz, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `load_start`  in  1  one-cycle pulse; latches `load_len` and starts a load.
- `load_len`  in  ADDR_W+1  byte count to load, 0..DEPTH.
- `in_valid`  in  1  `in_data` is valid.
- `in_data`  in  8  input byte.
- `in_ready`  out  1  loader accepts a byte this cycle.
- `mem_we`  out  1  memory write enable, single-cycle pulse.
- `mem_addr`  out  ADDR_W  memory write address.
- `mem_wdata`  out  8  memory write data.
- `crc_out`  out  16  running CRC; final value is valid while `load_done`=1.
- `load_done`  out  1  level; load complete.
- `busy`  out  1  a load is in progress (ACCEPT or WRITE).

## Operation
- Reset values: all outputs 0, except `crc_out` = `CRC_INIT`. State = IDLE. Internal byte counter = 0.
- States:
  - IDLE: `in_ready`=0.
    - `load_start` → clear address and count, preset CRC to `CRC_INIT`, latch `load_len`.
    - Latched length 0 → DONE directly.
    - Otherwise → ACCEPT.
  - ACCEPT: `in_ready`=1.
    - Handshake (`in_valid && in_ready`) → register `in_data` into `mem_wdata` → WRITE.
    - No handshake → stay in ACCEPT.
  - WRITE: `mem_we`=1 for exactly one cycle at the current `mem_addr`. In the same cycle, CRC updates to `crc_next(crc, byte)` and count increments.
    - Count reaches latched length → DONE.
    - Otherwise → `mem_addr`+1, then ACCEPT.
  - DONE: `load_done`=1; `crc_out` held.
    - `load_start` → behaves as in IDLE (restart; `load_done` falls the next cycle).
- CRC arithmetic:
  - MSB-first, no input/output reflection, no final XOR.
  - Byte update = 8 serial shift/XOR steps, unrolled combinationally.
- Width rules:
  - `load_len` values above DEPTH saturate to DEPTH.
  - `mem_addr` never wraps; the last write is at DEPTH-1.
- `load_start` while `busy`=1 is ignored; the current load continues.
- `in_valid` while `in_ready`=0 is not consumed. The source must hold the byte stable until the handshake.
- Asynchronous reset mid-load:
  - Immediate return to IDLE with reset values.
  - Memory contents are left as written.
  - `load_done` stays 0.

## Timing
- Throughput: at most 1 byte per 2 cycles (ACCEPT, WRITE).
- Latency from handshake edge N:
  - `mem_we` high in cycle N+1.
  - `crc_out` includes that byte from cycle N+2.
- `load_done` rises the cycle after the final WRITE.
- From `load_start` edge to `in_ready`=1: 1 cycle.
- `mem_addr` and `mem_wdata` are stable throughout the `mem_we` cycle.
- All outputs are registered except `in_ready` and `mem_we`, which are decoded from state.

## Structure
- Shared package `crc_pkg`, containing:
  - state enum `loader_state_t` {IDLE, ACCEPT, WRITE, DONE}.
  - `CRC16_POLY`, `CRC16_INIT`, `MEM_DEPTH`, `MEM_ADDR_W` constants.
  - the function `crc16_byte(crc, data)`.
- Sub-module `crc16_byte_update`: combinational byte-wise CRC step. It is instantiated here and reusable by the checker.
- Top module holds:
  - the FSM (separate sequential and combinational processes);
  - the address/count registers;
  - the CRC register.

## Test plan
- Reset: assert `rst_n`=0 at arbitrary points → all outputs 0, `crc_out`=16'hFFFF, `in_ready`=0.
- Check vector: `load_len`=9, bytes "123456789" with continuous `in_valid`:
  - writes to addresses 0..8;
  - `load_done`=1 with `crc_out`=16'h29B1;
  - exactly 9 `mem_we` pulses.
- Backpressure/gaps: same 9 bytes with random `in_valid` gaps → identical memory contents and CRC 16'h29B1; no byte dropped or duplicated.
- Full depth: `load_len`=1024, bytes = addr[7:0]:
  - last write at address 1023;
  - no wrap;
  - `crc_out` matches the reference model.
  - Then `load_len`=1100 → saturates at 1024 writes.
- Edge lengths:
  - `load_len`=0 → DONE one cycle after start, `crc_out`=16'hFFFF, no `mem_we`.
  - `load_len`=1, byte 8'h00 → `crc_out`=16'hE1F0.
- Disturbances:
  - `load_start` pulsed mid-load → ignored.
  - `rst_n` dropped after 5 bytes → IDLE.
  - A new load of "123456789" then completes with 16'h29B1.
